// File: rtl/rtc_bus_reader.sv
// Reads seconds..year from the RTC over the AD/CS/WR/RD bus and publishes them as one snapshot.
// Latency 6*FRAME_LEN cycles from the chs rising edge to done; chs edges are ignored while busy.
module rtc_bus_reader #(
  parameter logic [7:0] ADDR_BASE = 8'h21,
  parameter int         FRAME_LEN = 35
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chs,
  input  logic [7:0] ADin,
  output logic [7:0] ADout,
  output logic       oe,
  output logic       ad,
  output logic       wr,
  output logic       rd,
  output logic       cs,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] year,
  output logic       busy,
  output logic       done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [6:0] CNT_LAST = 7'(FRAME_LEN - 1);
  localparam logic [2:0] IDX_LAST = 3'd5;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  adout_q, adout_d;
  logic        oe_q, oe_d;
  logic        ad_q, ad_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        cs_q, cs_d;
  logic        done_q, done_d;
  logic        chs_q, chs_d;
  logic [7:0]  shadow_q [6];
  logic [7:0]  shadow_d [6];
  logic [7:0]  snap_q [6];
  logic [7:0]  snap_d [6];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      adout_q <= '0;
      oe_q    <= 1'b0;
      ad_q    <= 1'b1;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      chs_q   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      adout_q <= adout_d;
      oe_q    <= oe_d;
      ad_q    <= ad_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      chs_q   <= chs_d;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= shadow_d[i];
        snap_q[i]   <= snap_d[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    adout_d  = adout_q;
    oe_d     = oe_q;
    ad_d     = ad_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cs_d     = cs_q;
    done_d   = 1'b0;
    chs_d    = chs;
    shadow_d = shadow_q;
    snap_d   = snap_q;

    case (state_q)
      ST_IDLE: begin
        if (chs && !chs_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 7'd1;
        // Address phase (cnt 0..11), then RD-strobed data phase (cnt 15..23).
        case (cnt_q)
          7'd0: begin
            ad_d   = 1'b1;
            wr_d   = 1'b1;
            rd_d   = 1'b1;
            cs_d   = 1'b1;
            addr_d = ADDR_BASE + {5'd0, idx_q};
          end
          7'd1:  ad_d = 1'b0;
          7'd2:  cs_d = 1'b0;
          7'd3:  wr_d = 1'b0;
          7'd4: begin
            adout_d = addr_q;
            oe_d    = 1'b1;
          end
          7'd8:  wr_d = 1'b1;
          7'd9:  cs_d = 1'b1;
          7'd10: ad_d = 1'b1;
          7'd11: begin
            oe_d    = 1'b0;
            adout_d = 8'h00;
          end
          7'd15: cs_d = 1'b0;
          7'd16: rd_d = 1'b0;
          7'd21: begin
            for (int i = 0; i < 6; i++) begin
              if (idx_q == 3'(i)) shadow_d[i] = ADin;
            end
          end
          7'd22: rd_d = 1'b1;
          7'd23: cs_d = 1'b1;
          default: ;
        endcase
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            // Last byte already sits in its shadow slot, so all six publish together.
            snap_d  = shadow_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ADout = adout_q;
  assign oe    = oe_q;
  assign ad    = ad_q;
  assign wr    = wr_q;
  assign rd    = rd_q;
  assign cs    = cs_q;
  assign seg   = snap_q[0];
  assign min   = snap_q[1];
  assign hora  = snap_q[2];
  assign dia   = snap_q[3];
  assign mes   = snap_q[4];
  assign year  = snap_q[5];
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader with a small RTC model and a running bus-protocol checker.
module tb_rtc_bus_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       chs   = 1'b0;
  logic [7:0] ADin;
  logic [7:0] ADout;
  logic       oe, ad, wr, rd, cs, busy, done;
  logic [7:0] seg, min, hora, dia, mes, year;

  rtc_bus_reader dut (
    .clock(clock), .reset(reset), .chs(chs), .ADin(ADin), .ADout(ADout),
    .oe(oe), .ad(ad), .wr(wr), .rd(rd), .cs(cs),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .year(year),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  wire [47:0] snap = {seg, min, hora, dia, mes, year};

  // RTC model: address latched during the address phase, data driven only while rd is low.
  logic [7:0] rom [6];
  logic [7:0] rtc_addr = 8'h00;

  always_comb begin
    ADin = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      if (!rd && rtc_addr == 8'(8'h21 + i)) ADin = rom[i];
    end
  end

  int         cyc = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         ad_fall_t = 0;
  int         cs_fall_t = 0;
  logic [7:0] addr_log [$];
  logic       ad_p = 1'b1, cs_p = 1'b1, wr_p = 1'b1, rd_p = 1'b1, oe_p = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (oe && !wr) rtc_addr <= ADout;
    if (oe && !oe_p && !wr) addr_log.push_back(ADout);
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    chk("rd_low_while_oe", {63'd0, !rd && oe}, 64'd0);
    chk("wr_rd_both_low", {63'd0, !wr && !rd}, 64'd0);
    if (ad_p && !ad) ad_fall_t = cyc;
    if (cs_p && !cs) cs_fall_t = cyc;
    if (wr_p && !wr) chk("ad_cs_wr_order", {61'd0, ad, cs, ad_fall_t < cs_fall_t}, 64'b001);
    if (rd_p && !rd) chk("cs_low_at_rd", {63'd0, cs}, 64'd0);
    ad_p = ad; cs_p = cs; wr_p = wr; rd_p = rd; oe_p = oe;
  end

  task automatic start_read(output int s);
    chs = 1'b1;
    s = cyc + 1;
    @(negedge clock);
    chs = 1'b0;
  endtask

  task automatic wait_done(input int s, input logic [47:0] old, output int lat, output int early);
    lat = -1;
    early = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done) begin
        lat = cyc - s;
        break;
      end
      if (snap !== old) early++;
    end
    if (lat < 0) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic set_rom(input logic [47:0] v);
    for (int i = 0; i < 6; i++) rom[i] = v[47 - 8*i -: 8];
  endtask

  int s, lat, early, base_done, base_busy, base_addr;

  initial begin
    set_rom(48'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chs = ~chs;
    end
    @(negedge clock);
    chk("rst_ctrl", {57'd0, ad, wr, rd, cs, oe, busy, done}, 64'b1111000);
    chk("rst_adout", {56'd0, ADout}, 64'h00);
    chk("rst_snap", {16'd0, snap}, 64'h0);
    chs = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Single read
    set_rom(48'h453012230316);
    base_done = done_cnt;
    base_addr = addr_log.size();
    start_read(s);
    wait_done(s, 48'h0, lat, early);
    chk("single_latency", 64'(lat), 64'd210);
    chk("single_early", 64'(early), 64'd0);
    chk("single_snap", {16'd0, snap}, 64'h453012230316);
    chk("single_busy_at_done", {63'd0, busy}, 64'd0);
    chk("single_nphases", 64'(addr_log.size() - base_addr), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (base_addr + i < addr_log.size())
        chk($sformatf("addr_phase%0d", i), {56'd0, addr_log[base_addr + i]}, 64'(8'h21 + i));
    end
    @(negedge clock);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("single_done_cnt", 64'(done_cnt - base_done), 64'd1);

    // Retrigger immunity: chs held high with an extra pulse while busy
    set_rom(48'h010203040506);
    base_done = done_cnt;
    base_busy = busy_cnt;
    for (int i = 0; i < 400; i++) begin
      if (i == 0) chs = 1'b1;
      if (i == 99) chs = 1'b0;
      if (i == 100) chs = 1'b1;
      @(negedge clock);
    end
    chs = 1'b0;
    repeat (5) @(negedge clock);
    chk("retrig_done_cnt", 64'(done_cnt - base_done), 64'd1);
    chk("retrig_busy_cycles", 64'(busy_cnt - base_busy), 64'd210);
    chk("retrig_snap", {16'd0, snap}, 64'h010203040506);

    // Reset in the middle of a sequence
    set_rom(48'h112233445566);
    base_done = done_cnt;
    start_read(s);
    repeat (118) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ctrl", {57'd0, ad, wr, rd, cs, oe, busy, done}, 64'b1111000);
    chk("midrst_snap", {16'd0, snap}, 64'h0);
    reset = 1'b1;
    repeat (300) @(negedge clock);
    chk("midrst_no_done", 64'(done_cnt - base_done), 64'd0);
    set_rom(48'h665544332211);
    start_read(s);
    wait_done(s, 48'h0, lat, early);
    chk("postrst_latency", 64'(lat), 64'd210);
    chk("postrst_snap", {16'd0, snap}, 64'h665544332211);

    // Snapshot atomicity, then a back-to-back read right after done
    repeat (3) @(negedge clock);
    set_rom({6{8'hAA}});
    start_read(s);
    wait_done(s, 48'h665544332211, lat, early);
    chk("old_snap_aa", {16'd0, snap}, {16'd0, {6{8'hAA}}});
    repeat (2) @(negedge clock);
    set_rom({6{8'h55}});
    start_read(s);
    wait_done(s, {6{8'hAA}}, lat, early);
    chk("atom_hold_aa", 64'(early), 64'd0);
    chk("atom_latency", 64'(lat), 64'd210);
    chk("atom_switch_55", {16'd0, snap}, {16'd0, {6{8'h55}}});
    set_rom(48'h0A0B0C0D0E0F);
    start_read(s);
    chk("b2b_done_low", {63'd0, done}, 64'd0);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(s, {6{8'h55}}, lat, early);
    chk("b2b_latency", 64'(lat), 64'd210);
    chk("b2b_early", 64'(early), 64'd0);
    chk("b2b_snap", {16'd0, snap}, 64'h0A0B0C0D0E0F);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_reader.md
Name: rtc_bus_reader

Overview:
- Reads the six time/date registers (seconds, minutes, hours, day, month, year) from the external RTC over the multiplexed AD/CS/WR/RD bus.
- Uses the same per-transaction address phase as the date-write sequencer, followed by an RD-strobed data phase.
- Sits beside the date writer. A top-level mux grants the bus to one block at a time.
- Presents a consistent snapshot of all six bytes to the display/control logic.

Parameters:
- ADDR_BASE, 8'h21, address of the seconds register. The six registers are read at ADDR_BASE+0 .. ADDR_BASE+5, in order seconds, minutes, hours, day, month, year.
- FRAME_LEN, 35, clock cycles per register transaction. Legal range 25..127.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- chs  in  1  read request; a 0->1 transition starts a full six-register read.
- ADin  in  8  RTC AD bus as seen by this block.
- ADout  out  8  address byte driven onto the AD bus.
- oe  out  1  AD bus drive enable; top level tri-states ADout when oe=0.
- ad  out  1  address strobe (ALE-style).
- wr  out  1  write strobe, active-low.
- rd  out  1  read strobe, active-low.
- cs  out  1  chip select, active-low.
- seg, min, hora, dia, mes, year  out  8 each  last completed snapshot.
- busy  out  1  high while a read sequence is in progress.
- done  out  1  one-cycle pulse when a snapshot is published.

Behaviour:
- Reset (reset=0 at an edge):
  - ad=wr=rd=cs=1, oe=0, ADout=8'h00.
  - All six snapshot outputs = 8'h00; busy=0, done=0.
  - Internal counters and shadow registers cleared; the chs edge detector register is cleared to 0.
  - Reset asserted mid-sequence aborts it: no done pulse, snapshot outputs cleared.
- Idle: strobes held at 1, oe=0, busy=0.
- Start: at an edge with chs=1 and the registered previous chs=0, while busy=0:
  - busy<=1, frame counter cnt<=0, register index idx<=0.
  - A chs edge while busy=1 is ignored; chs held high does not retrigger.
- Frame sequencing: cnt increments every cycle while busy. Actions keyed on the cnt value at the edge, visible after that edge:
  - cnt=0: ad,wr,rd,cs<=1; latch addr=ADDR_BASE+idx (8-bit, wraps mod 256).
  - cnt=1: ad<=0.
  - cnt=2: cs<=0.
  - cnt=3: wr<=0.
  - cnt=4: ADout<=addr, oe<=1.
  - cnt=8: wr<=1.
  - cnt=9: cs<=1.
  - cnt=10: ad<=1.
  - cnt=11: oe<=0, ADout<=8'h00.
  - cnt=15: cs<=0.
  - cnt=16: rd<=0.
  - cnt=21: shadow[idx]<=ADin (sampled while rd=0, cs=0).
  - cnt=22: rd<=1.
  - cnt=23: cs<=1.
  - cnt=FRAME_LEN-1, idx<5: cnt<=0, idx<=idx+1.
  - cnt=FRAME_LEN-1, idx=5: all six outputs<=shadow (byte 5 taken from its shadow slot, already captured at cnt=21), done<=1, busy<=0, cnt<=0, idx<=0.
  - All other cnt values: strobes unchanged.
- done is high exactly one cycle, then 0.
- Snapshot outputs change only on the publishing edge; partial reads are never visible.
- Total latency: 6*FRAME_LEN cycles from the start edge to the done edge (210 at default).
- wr is low only during the address phase; rd is never low while oe=1.
- Back-to-back operation: a new chs edge in the cycle after done starts a new sequence normally.

Test Plan:
- Reset: hold reset=0 for 3 cycles with chs toggling -> ad=wr=rd=cs=1, oe=0, busy=0, all snapshots 8'h00.
- Single read: RTC model returns 8'h45,8'h30,8'h12,8'h23,8'h03,8'h16 for addresses 8'h21..8'h26.
  - Pulse chs for 1 cycle.
  - Expect exactly six address phases carrying 8'h21..8'h26 while oe=1 and wr=0.
  - Expect done after 210 cycles; seg=8'h45, min=8'h30, hora=8'h12, dia=8'h23, mes=8'h03, year=8'h16.
- Protocol checker (running across all scenarios):
  - Per frame: ad falls before cs, and cs falls before wr.
  - ADin sampled at cnt 21 with rd=0 and cs=0.
  - Assertion failure if rd=0 while oe=1, or if wr=0 and rd=0 simultaneously.
- Retrigger immunity: hold chs=1 for 400 cycles, and add a second chs pulse at cycle 100 -> exactly one done pulse; busy=1 for 210 cycles.
- Reset mid-read: assert reset at cycle 120 of a sequence -> no done pulse, strobes return to 1 next edge, snapshots 8'h00. A new chs edge then completes normally with fresh data.
- Snapshot atomicity: start a read with an old snapshot of all 8'hAA and new RTC data of all 8'h55 -> outputs stay 8'hAA until the done edge, then all six switch to 8'h55 on the same cycle.
